// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver: synchronises and glitch-filters the mouse lines,
// deframes start/8 data/odd parity/stop frames and flags parity, stop and timeout faults.
module ps2_byte_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic [7:0] BYTE_READ,
  output logic       BYTE_READY,
  output logic [1:0] BYTE_ERROR,
  output logic       TIMEOUT,
  output logic       BUSY
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_mouse_p0, clk_mouse_p1;
  logic          data_mouse_p0, data_mouse_p1;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          strobe;
  logic [1:0]    state;
  logic [3:0]    bitcnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tcnt;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TW'(TIMEOUT_CYCLES)) ? v : v + 1'b1;
  endfunction

  // stage p0/p1: two-flop synchroniser on both PS/2 lines
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_mouse_p0  <= 1'b1;
      clk_mouse_p1  <= 1'b1;
      data_mouse_p0 <= 1'b1;
      data_mouse_p1 <= 1'b1;
    end else begin
      clk_mouse_p0  <= CLK_MOUSE_IN;
      clk_mouse_p1  <= clk_mouse_p0;
      data_mouse_p0 <= DATA_MOUSE_IN;
      data_mouse_p1 <= data_mouse_p0;
    end
  end

  // filter stage: the filtered clock only follows after FILTER_LEN differing samples in a row
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_mouse_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_mouse_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe = filt_clk_d & ~filt_clk;
  assign BUSY   = (state != IDLE);

  // deframing stage: advances on STROBE; ENABLE low and timeout both override a strobe
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      BYTE_READ  <= 8'h00;
      BYTE_READY <= 1'b0;
      BYTE_ERROR <= 2'b00;
      TIMEOUT    <= 1'b0;
    end else begin
      BYTE_READY <= 1'b0;
      TIMEOUT    <= 1'b0;
      if (!ENABLE) begin
        state   <= IDLE;
        bitcnt  <= '0;
        shift   <= '0;
        par_bit <= 1'b0;
        tcnt    <= '0;
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
        state   <= IDLE;
        bitcnt  <= '0;
        shift   <= '0;
        par_bit <= 1'b0;
        tcnt    <= '0;
        TIMEOUT <= 1'b1;
      end else begin
        if (state == IDLE || strobe) tcnt <= '0;
        else                         tcnt <= sat_inc(tcnt);
        if (strobe) begin
          case (state)
            IDLE: begin
              if (!data_mouse_p1) begin
                state  <= DATA;
                bitcnt <= '0;
              end
            end
            DATA: begin
              shift  <= {data_mouse_p1, shift[7:1]};
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) state <= PARITY;
            end
            PARITY: begin
              par_bit <= data_mouse_p1;
              state   <= STOP;
            end
            default: begin
              state         <= IDLE;
              bitcnt        <= '0;
              BYTE_READY    <= 1'b1;
              BYTE_READ     <= shift;
              BYTE_ERROR[0] <= ((^shift) ^ par_bit) == 1'b0;
              BYTE_ERROR[1] <= ~data_mouse_p1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Scoreboard bench for ps2_byte_receiver: directed PS/2 frames, glitches, timeout,
// enable and reset interruptions, with expected bytes queued ahead of the monitor.
`timescale 1ns/1ps
module tb_ps2_byte_receiver;

  localparam int F    = 8;
  localparam int TO   = 400;
  localparam int HALF = 50;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b1;
  logic       clk_mouse = 1'b1;
  logic       data_mouse = 1'b1;
  logic [7:0] BYTE_READ;
  logic       BYTE_READY;
  logic [1:0] BYTE_ERROR;
  logic       TIMEOUT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         to;
    logic [7:0] b;
    logic [1:0] e;
  } exp_t;
  exp_t sb[$];

  ps2_byte_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .CLK_MOUSE_IN(clk_mouse), .DATA_MOUSE_IN(data_mouse),
    .BYTE_READ(BYTE_READ), .BYTE_READY(BYTE_READY), .BYTE_ERROR(BYTE_ERROR),
    .TIMEOUT(TIMEOUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit to, input logic [7:0] b, input logic [1:0] e);
    exp_t x;
    x.to = to; x.b = b; x.e = e;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // Drives frame bits first..last; data changes while the line clock is high.
  task automatic send_bits(input logic [10:0] frame, input int first, input int last,
                           input int glitch_bit, input bit chk_lat);
    for (int i = first; i <= last; i++) begin
      data_mouse = frame[i];
      if (i == glitch_bit) begin
        wait_cyc(10);
        clk_mouse = 1'b0;
        wait_cyc(F - 1);
        clk_mouse = 1'b1;
        wait_cyc(HALF - 10 - (F - 1));
      end else begin
        wait_cyc(HALF);
      end
      clk_mouse = 1'b0;
      if (chk_lat && i == 10) begin
        repeat (F + 2) @(posedge CLK);
        #1 check("latency_early", BYTE_READY, 1'b0);
        @(posedge CLK);
        #1 check("latency_on", BYTE_READY, 1'b1);
        wait_cyc(HALF - (F + 3));
      end else begin
        wait_cyc(HALF);
      end
      clk_mouse = 1'b1;
    end
  endtask

  // Monitor: every ready/timeout pulse pops one expected entry.
  always @(posedge CLK) begin
    exp_t x;
    #1;
    if (BYTE_READY || TIMEOUT) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: ready=%0b timeout=%0b byte=%h expected none at %0t",
                 BYTE_READY, TIMEOUT, BYTE_READ, $time);
      end else begin
        x = sb.pop_front();
        check("pulse_timeout", TIMEOUT, x.to);
        check("pulse_ready", BYTE_READY, !x.to);
        check("byte_read", BYTE_READ, x.b);
        if (!x.to) check("byte_error", BYTE_ERROR, x.e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst_byte_read", BYTE_READ, 8'h00);
    check("rst_ready", BYTE_READY, 1'b0);
    check("rst_error", BYTE_ERROR, 2'b00);
    check("rst_timeout", TIMEOUT, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    wait_cyc(2);
    RESET = 1'b1;
    wait_cyc(20);

    // Single clean frame with latency check
    push(0, 8'hFA, 2'b00);
    send_bits(mk(8'hFA, 1'b1, 1'b1), 0, 10, -1, 1'b1);
    wait_cyc(HALF);

    // Back-to-back frames
    push(0, 8'hAA, 2'b00);
    send_bits(mk(8'hAA, 1'b1, 1'b1), 0, 10, -1, 1'b0);
    push(0, 8'h00, 2'b00);
    send_bits(mk(8'h00, 1'b1, 1'b1), 0, 10, -1, 1'b0);
    push(0, 8'h08, 2'b00);
    send_bits(mk(8'h08, 1'b0, 1'b1), 0, 10, -1, 1'b0);
    wait_cyc(HALF);

    // Parity error, then stop-bit error
    push(0, 8'hAA, 2'b01);
    send_bits(mk(8'hAA, 1'b0, 1'b1), 0, 10, -1, 1'b0);
    wait_cyc(HALF);
    push(0, 8'h55, 2'b10);
    send_bits(mk(8'h55, 1'b1, 1'b0), 0, 10, -1, 1'b0);
    data_mouse = 1'b1;
    wait_cyc(HALF);

    // Stalled frame: start + 5 data bits, then idle beyond the timeout
    send_bits(mk(8'hF4, 1'b0, 1'b1), 0, 5, -1, 1'b0);
    data_mouse = 1'b1;
    @(posedge CLK); #1 check("busy_mid_frame", BUSY, 1'b1);
    push(1, 8'h55, 2'b00);
    wait_cyc(500);
    @(posedge CLK); #1 check("busy_after_timeout", BUSY, 1'b0);
    push(0, 8'hF4, 2'b00);
    send_bits(mk(8'hF4, 1'b0, 1'b1), 0, 10, -1, 1'b0);
    wait_cyc(HALF);

    // Short clock glitches while idle and in the middle of a bit
    clk_mouse = 1'b0;
    wait_cyc(F - 1);
    clk_mouse = 1'b1;
    wait_cyc(HALF);
    @(posedge CLK); #1 check("busy_after_idle_glitch", BUSY, 1'b0);
    push(0, 8'h3C, 2'b00);
    send_bits(mk(8'h3C, 1'b1, 1'b1), 0, 10, 3, 1'b0);
    wait_cyc(HALF);

    // ENABLE dropped after 4 data bits
    send_bits(mk(8'h12, 1'b1, 1'b1), 0, 4, -1, 1'b0);
    ENABLE = 1'b0;
    wait_cyc(3);
    @(posedge CLK); #1 check("busy_disabled", BUSY, 1'b0);
    wait_cyc(5);
    ENABLE = 1'b1;
    wait_cyc(600);

    // ENABLE low across the stop-bit strobe suppresses the byte
    send_bits(mk(8'h66, 1'b1, 1'b1), 0, 9, -1, 1'b0);
    ENABLE = 1'b0;
    send_bits(mk(8'h66, 1'b1, 1'b1), 10, 10, -1, 1'b0);
    wait_cyc(5);
    ENABLE = 1'b1;
    wait_cyc(HALF);

    // Reset pulsed mid-frame
    send_bits(mk(8'h81, 1'b1, 1'b1), 0, 6, -1, 1'b0);
    RESET = 1'b0;
    #1 check("midrst_byte_read", BYTE_READ, 8'h00);
    check("midrst_busy", BUSY, 1'b0);
    wait_cyc(4);
    RESET = 1'b1;
    wait_cyc(600);
    push(0, 8'hFA, 2'b00);
    send_bits(mk(8'hFA, 1'b1, 1'b1), 0, 10, -1, 1'b0);
    wait_cyc(HALF);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
